// File: rtl/uart_csr_bank.sv
// uart_csr_bank: per-channel UART control/status register banks behind one
// memory-style access port. Each channel occupies a 0x20-byte window holding
// CTRL, BAUD, INT_EN, W1C INT_STAT, read-only STATUS and a write-only TXDATA
// register that strobes tx_wr. Reads return one cycle after the request.
module uart_csr_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = 4,
  parameter int unsigned NUM_CH     = 4,
  parameter logic [15:0] BAUD_RST   = 16'd868
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cs,
  input  logic                    wen,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [STRB_WIDTH-1:0]   strb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    err,
  output logic [NUM_CH*8-1:0]     ctrl,
  output logic [NUM_CH*16-1:0]    baud,
  output logic [NUM_CH*8-1:0]     tx_data,
  output logic [NUM_CH-1:0]       tx_wr,
  input  logic [NUM_CH*8-1:0]     status,
  input  logic [NUM_CH*4-1:0]     ev,
  output logic [NUM_CH-1:0]       irq
);

  localparam int unsigned CH_W = ADDR_WIDTH - 5;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_BAUD     = 3'd1;
  localparam logic [2:0] OFF_INT_EN   = 3'd2;
  localparam logic [2:0] OFF_INT_STAT = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [2:0] OFF_TXDATA   = 3'd5;

  logic [7:0]            r_ctrl     [NUM_CH];
  logic [15:0]           r_baud     [NUM_CH];
  logic [3:0]            r_int_en   [NUM_CH];
  logic [3:0]            r_int_stat [NUM_CH];
  logic [7:0]            r_tx_data  [NUM_CH];
  logic [NUM_CH-1:0]     r_tx_wr;
  logic [NUM_CH-1:0]     r_irq;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_err;

  logic [CH_W-1:0]       w_ch;
  logic [2:0]            w_off;
  logic [NUM_CH-1:0]     w_sel;
  logic                  w_ch_ok;
  logic                  w_mapped;
  logic                  w_wr;
  logic                  w_rd;
  logic [3:0]            w_clr [NUM_CH];
  logic [DATA_WIDTH-1:0] w_rd_val;
  logic                  w_unused;

  assign w_ch     = addr[ADDR_WIDTH-1:5];
  assign w_off    = addr[4:2];
  assign w_ch_ok  = |w_sel;
  assign w_mapped = w_ch_ok && (w_off <= OFF_TXDATA);
  assign w_wr     = cs && wen && w_mapped;
  assign w_rd     = cs && !wen;

  // Bits that carry no register content: upper data lanes, upper strobes, byte offset.
  assign w_unused = ^{wdata[DATA_WIDTH-1:16], strb[STRB_WIDTH-1:2], addr[1:0]};

  // One-hot channel select; all-zero for a channel index beyond NUM_CH-1.
  always_comb begin
    w_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel[c] = (w_ch == CH_W'(c));
    end
  end

  // Per-channel W1C clear mask, only for a lane-0 write to INT_STAT.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_clr[c] = '0;
      if (w_wr && w_sel[c] && (w_off == OFF_INT_STAT) && strb[0]) begin
        w_clr[c] = wdata[3:0];
      end
    end
  end

  // Read mux; unimplemented bits, TXDATA and unmapped slots read as zero.
  always_comb begin
    w_rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_sel[c]) begin
        case (w_off)
          OFF_CTRL:     w_rd_val = DATA_WIDTH'(r_ctrl[c]);
          OFF_BAUD:     w_rd_val = DATA_WIDTH'(r_baud[c]);
          OFF_INT_EN:   w_rd_val = DATA_WIDTH'(r_int_en[c]);
          OFF_INT_STAT: w_rd_val = DATA_WIDTH'(r_int_stat[c]);
          OFF_STATUS:   w_rd_val = DATA_WIDTH'(status[c*8 +: 8]);
          default:      w_rd_val = '0;
        endcase
      end
    end
  end

  // Channel register state, TX strobe and interrupt generation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_ctrl[c]     <= '0;
        r_baud[c]     <= BAUD_RST;
        r_int_en[c]   <= '0;
        r_int_stat[c] <= '0;
        r_tx_data[c]  <= '0;
      end
      r_tx_wr <= '0;
      r_irq   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_tx_wr[c]    <= 1'b0;
        r_irq[c]      <= |(r_int_stat[c] & r_int_en[c]);
        // Event set is applied after the clear so a coincident event wins.
        r_int_stat[c] <= (r_int_stat[c] & ~w_clr[c]) | ev[c*4 +: 4];
        if (w_wr && w_sel[c]) begin
          case (w_off)
            OFF_CTRL: begin
              if (strb[0]) r_ctrl[c] <= wdata[7:0];
            end
            OFF_BAUD: begin
              if (strb[0]) r_baud[c][7:0]  <= wdata[7:0];
              if (strb[1]) r_baud[c][15:8] <= wdata[15:8];
            end
            OFF_INT_EN: begin
              if (strb[0]) r_int_en[c] <= wdata[3:0];
            end
            OFF_TXDATA: begin
              if (strb[0]) begin
                r_tx_data[c] <= wdata[7:0];
                r_tx_wr[c]   <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Registered read response and unmapped-access flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      r_rdata  <= (w_rd && w_mapped) ? w_rd_val : '0;
      r_err    <= cs && !w_mapped;
    end
  end

  // Flatten per-channel registers onto the output buses.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign ctrl[g*8 +: 8]     = r_ctrl[g];
    assign baud[g*16 +: 16]   = r_baud[g];
    assign tx_data[g*8 +: 8]  = r_tx_data[g];
  end

  assign tx_wr  = r_tx_wr;
  assign irq    = r_irq;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign err    = r_err;

endmodule

// File: tb/tb_uart_csr_bank.sv
// Directed bench for uart_csr_bank (4 channels, BAUD_RST 0x364).
module tb_uart_csr_bank;

  localparam int unsigned NCH = 4;

  logic          clk;
  logic          rstn;
  logic          cs;
  logic          wen;
  logic [15:0]   addr;
  logic [3:0]    strb;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          rvalid;
  logic          err;
  logic [31:0]   ctrl;
  logic [63:0]   baud;
  logic [31:0]   tx_data;
  logic [3:0]    tx_wr;
  logic [31:0]   status;
  logic [15:0]   ev;
  logic [3:0]    irq;

  int n_cmp;
  int n_bad;

  uart_csr_bank #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .NUM_CH(NCH), .BAUD_RST(16'd868)
  ) dut (
    .clk(clk), .rstn(rstn), .cs(cs), .wen(wen), .addr(addr), .strb(strb),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .err(err), .ctrl(ctrl),
    .baud(baud), .tx_data(tx_data), .tx_wr(tx_wr), .status(status), .ev(ev),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        wen;
    logic [15:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [3:0]  exp_txwr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic w, input logic [15:0] a,
                              input logic [3:0] s, input logic [31:0] d,
                              input logic rv, input logic [31:0] rd,
                              input logic er, input logic [3:0] tw);
    vec_t v;
    v.cs = c; v.wen = w; v.addr = a; v.strb = s; v.wdata = d;
    v.exp_rv = rv; v.exp_rd = rd; v.exp_err = er; v.exp_txwr = tw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One request cycle: drive at negedge, sample 1 time unit after the edge.
  task automatic step(input logic c, input logic w, input logic [15:0] a,
                      input logic [3:0] s, input logic [31:0] d, input logic [15:0] e);
    @(negedge clk);
    cs = c; wen = w; addr = a; strb = s; wdata = d; ev = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rstn = 1'b0; cs = 1'b0; wen = 1'b0; addr = '0; strb = '0; wdata = '0;
    ev = '0; status = 32'hD4C3_B2A1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", 64'(rvalid), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_tx_wr", 64'(tx_wr), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_ctrl", 64'(ctrl), 64'h0);
    chk("rst_baud", baud, 64'h0364_0364_0364_0364);
    chk("rst_tx_data", 64'(tx_data), 64'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Reset values, byte-lane writes, STATUS, TXDATA and unmapped accesses.
    vecs.push_back(mk(1, 0, 16'h0000, 4'h0, 32'h0,          1, 32'h0,   0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0004, 4'h0, 32'h0,          1, 32'h364, 0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0008, 4'h0, 32'h0,          1, 32'h0,   0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h000C, 4'h0, 32'h0,          1, 32'h0,   0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0060, 4'h0, 32'h0,          1, 32'h0,   0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0064, 4'h0, 32'h0,          1, 32'h364, 0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0068, 4'h0, 32'h0,          1, 32'h0,   0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h006C, 4'h0, 32'h0,          1, 32'h0,   0, 4'h0));
    vecs.push_back(mk(0, 0, 16'h0004, 4'h0, 32'h0,          0, 32'h0,   0, 4'h0));
    vecs.push_back(mk(1, 1, 16'h0044, 4'h1, 32'hA5A5_1234,  0, 32'h0,   0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0044, 4'h0, 32'h0,          1, 32'h334, 0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0047, 4'h0, 32'h0,          1, 32'h334, 0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0050, 4'h0, 32'h0,          1, 32'hC3,  0, 4'h0));
    vecs.push_back(mk(1, 1, 16'h0050, 4'hF, 32'hFFFF_FFFF,  0, 32'h0,   0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0050, 4'h0, 32'h0,          1, 32'hC3,  0, 4'h0));
    vecs.push_back(mk(1, 1, 16'h0020, 4'hF, 32'hFFFF_FF7E,  0, 32'h0,   0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0020, 4'h0, 32'h0,          1, 32'h7E,  0, 4'h0));
    vecs.push_back(mk(1, 1, 16'h0024, 4'h2, 32'h0000_BEEF,  0, 32'h0,   0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0024, 4'h0, 32'h0,          1, 32'hBE64,0, 4'h0));
    vecs.push_back(mk(1, 1, 16'h0028, 4'h1, 32'h0000_00F4,  0, 32'h0,   0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0028, 4'h0, 32'h0,          1, 32'h4,   0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h002C, 4'h0, 32'h0,          1, 32'h0,   0, 4'h0));
    vecs.push_back(mk(1, 1, 16'h0074, 4'h1, 32'h0000_005A,  0, 32'h0,   0, 4'h8));
    vecs.push_back(mk(1, 0, 16'h0074, 4'h0, 32'h0,          1, 32'h0,   0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0080, 4'h0, 32'h0,          1, 32'h0,   1, 4'h0));
    vecs.push_back(mk(1, 0, 16'h001C, 4'h0, 32'h0,          1, 32'h0,   1, 4'h0));
    vecs.push_back(mk(1, 1, 16'h0080, 4'hF, 32'hFFFF_FFFF,  0, 32'h0,   1, 4'h0));
    vecs.push_back(mk(1, 1, 16'h001C, 4'hF, 32'hFFFF_FFFF,  0, 32'h0,   1, 4'h0));
    vecs.push_back(mk(1, 1, 16'h0018, 4'hF, 32'hFFFF_FFFF,  0, 32'h0,   1, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0000, 4'h0, 32'h0,          1, 32'h0,   0, 4'h0));
    vecs.push_back(mk(1, 0, 16'h0004, 4'h0, 32'h0,          1, 32'h364, 0, 4'h0));

    foreach (vecs[i]) begin
      step(vecs[i].cs, vecs[i].wen, vecs[i].addr, vecs[i].strb, vecs[i].wdata, 16'h0);
      chk($sformatf("v%0d_rvalid", i), 64'(rvalid), 64'(vecs[i].exp_rv));
      chk($sformatf("v%0d_rdata", i),  64'(rdata),  64'(vecs[i].exp_rd));
      chk($sformatf("v%0d_err", i),    64'(err),    64'(vecs[i].exp_err));
      chk($sformatf("v%0d_tx_wr", i),  64'(tx_wr),  64'(vecs[i].exp_txwr));
    end

    chk("ctrl_ch0", 64'(ctrl[7:0]), 64'h00);
    chk("ctrl_ch1", 64'(ctrl[15:8]), 64'h7E);
    chk("baud_ch1", 64'(baud[31:16]), 64'hBE64);
    chk("baud_ch2", 64'(baud[47:32]), 64'h0334);
    chk("tx_data_ch3", 64'(tx_data[31:24]), 64'h5A);

    // Interrupt: sticky set, irq one cycle later, set beats same-cycle clear.
    step(0, 0, 16'h0, 4'h0, 32'h0, 16'h0040);
    chk("irq_not_yet", 64'(irq), 64'h0);
    step(0, 0, 16'h0, 4'h0, 32'h0, 16'h0000);
    chk("irq_set", 64'(irq), 64'h2);
    step(1, 0, 16'h002C, 4'h0, 32'h0, 16'h0000);
    chk("stat_sticky", 64'(rdata), 64'h4);
    step(1, 1, 16'h002C, 4'h1, 32'h4, 16'h0040);
    chk("irq_during_race", 64'(irq), 64'h2);
    step(1, 0, 16'h002C, 4'h0, 32'h0, 16'h0000);
    chk("stat_set_wins", 64'(rdata), 64'h4);
    step(1, 1, 16'h002C, 4'h2, 32'h4, 16'h0000);
    step(1, 0, 16'h002C, 4'h0, 32'h0, 16'h0000);
    chk("stat_no_lane0", 64'(rdata), 64'h4);
    step(1, 1, 16'h002C, 4'h1, 32'h4, 16'h0000);
    chk("irq_lags_clear", 64'(irq), 64'h2);
    step(1, 0, 16'h002C, 4'h0, 32'h0, 16'h0000);
    chk("stat_cleared", 64'(rdata), 64'h0);
    chk("irq_cleared", 64'(irq), 64'h0);

    // Back-to-back TXDATA writes, then a lane-0-less write.
    step(1, 1, 16'h0074, 4'h1, 32'h5A, 16'h0);
    chk("tx_b2b_1_wr", 64'(tx_wr), 64'h8);
    chk("tx_b2b_1_data", 64'(tx_data[31:24]), 64'h5A);
    step(1, 1, 16'h0074, 4'h1, 32'hC3, 16'h0);
    chk("tx_b2b_2_wr", 64'(tx_wr), 64'h8);
    chk("tx_b2b_2_data", 64'(tx_data[31:24]), 64'hC3);
    step(1, 1, 16'h0074, 4'h0, 32'h11, 16'h0);
    chk("tx_nostrb_wr", 64'(tx_wr), 64'h0);
    chk("tx_nostrb_data", 64'(tx_data[31:24]), 64'hC3);

    // Reset asserted while a TX pulse is live and a read is being issued.
    step(1, 1, 16'h0074, 4'h1, 32'h77, 16'h0);
    chk("pre_rst_tx_wr", 64'(tx_wr), 64'h8);
    @(negedge clk);
    cs = 1'b1; wen = 1'b0; addr = 16'h0024; strb = '0; wdata = '0;
    rstn = 1'b0;
    #1;
    chk("rst_mid_tx_wr", 64'(tx_wr), 64'h0);
    @(posedge clk);
    #1;
    chk("rst_mid_rvalid", 64'(rvalid), 64'h0);
    chk("rst_mid_rdata", 64'(rdata), 64'h0);
    chk("rst_mid_ctrl", 64'(ctrl), 64'h0);
    chk("rst_mid_baud", baud, 64'h0364_0364_0364_0364);
    chk("rst_mid_tx_data", 64'(tx_data), 64'h0);
    @(negedge clk);
    cs = 1'b0;
    rstn = 1'b1;
    step(1, 0, 16'h0024, 4'h0, 32'h0, 16'h0);
    chk("post_rst_rvalid", 64'(rvalid), 64'h1);
    chk("post_rst_rdata", 64'(rdata), 64'h364);
    step(0, 0, 16'h0, 4'h0, 32'h0, 16'h0);
    chk("post_rst_idle_rvalid", 64'(rvalid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
